// File: rtl/rx_bit_timer.sv
// Bit-timing engine for the RS-232 receive path: a half-period tick at the start-bit
// centre, then one tick per bit period. Optional bit_idx_o port under `RX_BIT_IDX_EN`.
module rx_bit_timer #(
    parameter int Width     = 15,
    parameter int BitsWidth = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic [Width-1:0]     vmax_i,
    input  logic [BitsWidth-1:0] nbits_i,
    output logic                 tick_o,
    output logic                 done_o,
    output logic                 busy_o
`ifdef RX_BIT_IDX_EN
    ,
    output logic [BitsWidth-1:0] bit_idx_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HALF = 2'd1,
        S_BIT  = 2'd2
    } state_e;

    state_e               r_state;
    logic [Width-1:0]     r_cnt;
    logic [BitsWidth-1:0] r_bits;
    logic [Width-1:0]     r_vmax;
    logic [BitsWidth-1:0] r_nbits;

    logic [Width-1:0]     w_target;
    logic                 w_active;
    logic                 w_last;
    logic                 w_hit;

    // Per-state compare target and final-tick qualifier
    always_comb begin
        w_target = r_vmax;
        w_active = 1'b0;
        w_last   = 1'b0;
        case (r_state)
            S_HALF: begin
                w_target = r_vmax >> 1;
                w_active = 1'b1;
                w_last   = (r_nbits == {BitsWidth{1'b0}});
            end
            S_BIT: begin
                w_target = r_vmax;
                w_active = 1'b1;
                // BIT is only entered with r_nbits != 0, so the subtraction cannot wrap here
                w_last   = (r_bits == (r_nbits - BitsWidth'(1)));
            end
            default: begin
                w_target = r_vmax;
                w_active = 1'b0;
                w_last   = 1'b0;
            end
        endcase
    end

    // Tick/done strobes; an abort suppresses both in the cycle it is seen
    always_comb begin
        w_hit = en_i && w_active && (r_cnt == w_target);
        if (stop_i) begin
            tick_o = 1'b0;
            done_o = 1'b0;
        end else begin
            tick_o = w_hit;
            done_o = w_hit && w_last;
        end
    end

    assign busy_o = (r_state != S_IDLE);
`ifdef RX_BIT_IDX_EN
    assign bit_idx_o = r_bits;
`endif

    // Frame state machine with counters; stop has priority over start and over a tick
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_cnt   <= {Width{1'b0}};
            r_bits  <= {BitsWidth{1'b0}};
            r_vmax  <= {Width{1'b0}};
            r_nbits <= {BitsWidth{1'b0}};
        end else if (stop_i) begin
            r_state <= S_IDLE;
            r_cnt   <= {Width{1'b0}};
            r_bits  <= {BitsWidth{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_vmax  <= vmax_i;
                        r_nbits <= nbits_i;
                        r_cnt   <= {Width{1'b0}};
                        r_bits  <= {BitsWidth{1'b0}};
                        r_state <= S_HALF;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_HALF, S_BIT: begin
                    if (!en_i) begin
                        r_state <= r_state;
                    end else if (w_hit) begin
                        r_cnt <= {Width{1'b0}};
                        if (r_state == S_BIT) begin
                            r_bits <= r_bits + BitsWidth'(1);
                        end else begin
                            r_bits <= r_bits;
                        end
                        if (w_last) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_BIT;
                        end
                    end else begin
                        r_cnt <= r_cnt + Width'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= {Width{1'b0}};
                    r_bits  <= {BitsWidth{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_bit_timer.sv
// Scoreboard bench for rx_bit_timer; expected ticks are queued per frame and
// retired at the busy-cycle index where they are due.
module tb_rx_bit_timer;
    localparam int W  = 15;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          start;
    logic          stop;
    logic [W-1:0]  vmax;
    logic [BW-1:0] nbits;
    logic          tick;
    logic          done;
    logic          busy;
`ifdef RX_BIT_IDX_EN
    logic [BW-1:0] bidx;
`endif

    typedef struct {
        int idx;
        bit dn;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    rx_bit_timer #(.Width(W), .BitsWidth(BW)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .en_i     (en),
        .start_i  (start),
        .stop_i   (stop),
        .vmax_i   (vmax),
        .nbits_i  (nbits),
        .tick_o   (tick),
        .done_o   (done),
        .busy_o   (busy)
`ifdef RX_BIT_IDX_EN
        ,
        .bit_idx_o(bidx)
`endif
    );

    always #5 clk = ~clk;

    task automatic push_tick(input int idx, input bit dn);
        exp_t e;
        e.idx = idx;
        e.dn  = dn;
        sbq.push_back(e);
    endtask

    // Issues a start pulse, then walks busy-cycle indices 0..ncyc-1 applying the scenario stimulus.
    task automatic run(input string name, input int vm, input int nb, input bit en0,
                       input int ncyc, input int b0, input int b1lo, input int b1hi,
                       input int stall_at, input int stall_len, input int stop_at,
                       input int start_at, input int new_vm, input int rst_at);
        int   bi;
        bit   first;
        bit   eb;
        bit   et;
        bit   ed;
        exp_t e;
        bi    = 0;
        first = 1'b1;
        vmax  = W'(vm);
        nbits = BW'(nb);
        en    = en0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        en    = 1'b1;
        for (int k = 0; k < ncyc; k++) begin
            en    = !(k >= stall_at && k < stall_at + stall_len);
            stop  = (k == stop_at);
            start = (k == start_at);
            if (k == start_at) vmax = W'(new_vm);
            if (rst_at >= 0 && k >= rst_at) begin
                rst_n = 1'b0;
                bi    = 0;
            end
            @(negedge clk);
            eb = (k < b0) || (k >= b1lo && k < b1hi);
            et = (sbq.size() > 0) && (sbq[0].idx == k);
            ed = et ? sbq[0].dn : 1'b0;
            if (et) e = sbq.pop_front();
            total++;
            if (busy !== eb) begin
                bad++;
                $display("FAIL %s busy k=%0d got=%b exp=%b", name, k, busy, eb);
            end
            total++;
            if (tick !== et || done !== ed) begin
                bad++;
                $display("FAIL %s tick/done k=%0d got=%b/%b exp=%b/%b", name, k, tick, done, et, ed);
            end
`ifdef RX_BIT_IDX_EN
            total++;
            if (bidx !== BW'(bi)) begin
                bad++;
                $display("FAIL %s bit_idx k=%0d got=%0d exp=%0d", name, k, bidx, bi);
            end
`endif
            if (k == stop_at) begin
                bi = 0;
            end else if (et) begin
                if (first) first = 1'b0;
                else bi++;
            end
            if (k == start_at && !eb) begin
                bi    = 0;
                first = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        stop  = 1'b0;
        start = 1'b0;
        en    = 1'b1;
        rst_n = 1'b1;
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL %s missing_ticks got=%0d_left exp=0", name, sbq.size());
        end
        sbq.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        vmax  = '0;
        nbits = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (tick !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset outputs got=%b%b%b exp=000", tick, done, busy);
        end
`ifdef RX_BIT_IDX_EN
        total++;
        if (bidx !== '0) begin
            bad++;
            $display("FAIL reset bit_idx got=%0d exp=0", bidx);
        end
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        for (int j = 0; j < 10; j++) push_tick(4 + 10 * j, j == 9);
        run("basic", 9, 9, 1'b1, 100, 95, -1, -1, -1, 0, -1, -1, 9, -1);
    endtask

    task automatic test_zero_bits();
        push_tick(3, 1'b1);
        run("zero_bits", 6, 0, 1'b0, 8, 4, -1, -1, -1, 0, -1, -1, 6, -1);
    endtask

    task automatic test_stall();
        push_tick(4, 1'b0);
        push_tick(17, 1'b0);
        push_tick(27, 1'b1);
        run("stall", 9, 2, 1'b1, 32, 28, -1, -1, 6, 3, -1, -1, 9, -1);
    endtask

    task automatic test_abort();
        push_tick(4, 1'b0);
        run("abort", 9, 9, 1'b1, 20, 15, -1, -1, -1, 0, 14, 14, 9, -1);
    endtask

    task automatic test_mid_frame_changes();
        for (int j = 0; j < 10; j++) push_tick(4 + 10 * j, j == 9);
        run("mid_change", 9, 9, 1'b1, 100, 95, -1, -1, -1, 0, -1, 20, 3, -1);
    endtask

    task automatic test_reset_mid_frame();
        for (int j = 0; j < 5; j++) push_tick(4 + 10 * j, 1'b0);
        run("reset_mid", 9, 9, 1'b1, 55, 50, -1, -1, -1, 0, -1, -1, 9, 50);
    endtask

    task automatic test_back_to_back();
        push_tick(3, 1'b1);
        push_tick(8, 1'b1);
        run("back_to_back", 6, 0, 1'b1, 12, 4, 5, 9, -1, 0, -1, 4, 6, -1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_bits();
        test_stall();
        test_abort();
        test_mid_frame_changes();
        test_reset_mid_frame();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
